// File: rtl/bec_pkg.sv
// bec_pkg: shared widths, LA command/slot encodings, LA bit positions and loader state enum
package bec_pkg;
  localparam int BEC_WIDTH = 163;
  localparam int BEC_WORDS = 6;
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ = 3'd2;
  localparam logic [2:0] CMD_START = 3'd3;
  localparam logic [2:0] CMD_CLEAR = 3'd4;
  localparam logic [2:0] SLOT_K = 3'd0;
  localparam logic [2:0] SLOT_X = 3'd1;
  localparam logic [2:0] SLOT_Y = 3'd2;
  localparam logic [2:0] SLOT_RX = 3'd0;
  localparam logic [2:0] SLOT_RY = 3'd1;
  localparam int LA_CMD = 32;
  localparam int LA_SLOT = 35;
  localparam int LA_IDX = 38;
  localparam int LA_REQ = 41;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_ISSUE, ST_WAIT} state_e;
endpackage

// File: rtl/bec_la_loader_if.sv
// bec_la_loader_if: core-side bus (master=loader drives op_*/res_ready, slave=core drives op_ready/res_*)
interface bec_la_loader_if import bec_pkg::*; #(
  parameter int WIDTH = BEC_WIDTH
) ();
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_k;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_x;
  logic [WIDTH-1:0] res_y;
  modport master (output op_valid, op_k, op_x, op_y, res_ready, input op_ready, res_valid, res_x, res_y);
  modport slave (input op_valid, op_k, op_x, op_y, res_ready, output op_ready, res_valid, res_x, res_y);
endinterface

// File: rtl/bec_word_reg.sv
// bec_word_reg: WIDTH-bit register with clr, 32-bit indexed write (we/idx/wdata), full load (ld/ldata), q and indexed read rdata
module bec_word_reg #(
  parameter int WIDTH = 163,
  parameter int WORDS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [2:0]       idx,
  input  logic [31:0]      wdata,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] q,
  output logic [31:0]      rdata
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb begin
    q_d = q_q;
    rdata = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (we && idx == 3'(b / 32)) q_d[b] = wdata[5'(b)];
      if (idx == 3'(b / 32)) rdata[5'(b)] = q_q[b];
    end
    q_d = clr ? '0 : ld ? ldata : q_d;
  end
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/bec_la_loader.sv
// bec_la_loader: LA toggle-command front end (la_data_in/la_oenb in, la_data_out status/rdata) loading k/x/y into the core bus and capturing its result
module bec_la_loader import bec_pkg::*; #(
  parameter int WIDTH = BEC_WIDTH,
  parameter int WORDS = BEC_WORDS
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [63:0]     la_data_in,
  input  logic [63:0]     la_oenb,
  output logic [63:0]     la_data_out,
  bec_la_loader_if.master core
);
  state_e state_q, state_d;
  logic req_sync_q, prev_req_q, prev_req_d, ack_q, ack_d, err_q, err_d, res_avail_q, res_avail_d;
  logic [2:0] cmd_q, cmd_d, slot_q, slot_d, idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic req, exec, idx_bad, wr_ok, rd_ok, clr, ld_res, busy, unused_ok;
  logic [4:0] we_v, ld_v;
  logic [4:0][WIDTH-1:0] ld_data, q_v;
  logic [4:0][31:0] rd_v;
  assign req = (req_sync_q != prev_req_q) && !la_oenb[LA_REQ] && state_q == ST_IDLE;
  assign exec = state_q == ST_EXEC;
  assign idx_bad = 32'(idx_q) >= WORDS;
  assign wr_ok = exec && cmd_q == CMD_WRITE && !idx_bad && slot_q <= SLOT_Y;
  assign rd_ok = !idx_bad && slot_q <= SLOT_RY;
  assign clr = exec && cmd_q == CMD_CLEAR;
  assign ld_res = state_q == ST_WAIT && core.res_valid;
  assign we_v = {2'b00, wr_ok && slot_q == SLOT_Y, wr_ok && slot_q == SLOT_X, wr_ok && slot_q == SLOT_K};
  assign ld_v = {ld_res, ld_res, 3'b000};
  assign ld_data = {core.res_y, core.res_x, {(3 * WIDTH){1'b0}}};
  for (genvar i = 0; i < 5; i++) begin : g_reg
    bec_word_reg #(.WIDTH(WIDTH), .WORDS(WORDS)) u_reg (
      .clk(wb_clk_i), .rst(wb_rst_i), .clr(clr), .we(we_v[i]), .idx(idx_q), .wdata(wdata_q),
      .ld(ld_v[i]), .ldata(ld_data[i]), .q(q_v[i]), .rdata(rd_v[i])
    );
  end
  assign core.op_k = q_v[0];
  assign core.op_x = q_v[1];
  assign core.op_y = q_v[2];
  assign core.op_valid = state_q == ST_ISSUE;
  assign core.res_ready = state_q == ST_WAIT;
  assign busy = core.op_valid || core.res_ready;
  assign la_data_out = {28'd0, err_q, res_avail_q, busy, ack_q, rdata_q};
  assign unused_ok = ^{la_data_in[63:42], la_oenb[63:42], la_oenb[40:0], q_v[4], q_v[3], rd_v[2:0]};
  always_comb begin
    state_d = state_q;
    prev_req_d = prev_req_q;
    cmd_d = cmd_q;
    slot_d = slot_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    ack_d = ack_q;
    err_d = err_q;
    rdata_d = rdata_q;
    res_avail_d = res_avail_q;
    case (state_q)
      ST_IDLE: if (req) begin
        state_d = ST_EXEC;
        prev_req_d = req_sync_q;
        cmd_d = la_data_in[LA_CMD +: 3];
        slot_d = la_data_in[LA_SLOT +: 3];
        idx_d = la_data_in[LA_IDX +: 3];
        wdata_d = la_data_in[31:0];
      end
      ST_EXEC: begin
        state_d = cmd_q == CMD_START ? ST_ISSUE : ST_IDLE;
        ack_d = cmd_q == CMD_START ? ack_q : !ack_q;
        if (cmd_q == CMD_START || cmd_q == CMD_CLEAR) res_avail_d = 1'b0;
        if (cmd_q == CMD_CLEAR) err_d = 1'b0;
        if ((cmd_q == CMD_WRITE && !wr_ok) || (cmd_q == CMD_READ && !rd_ok) || cmd_q > CMD_CLEAR) err_d = 1'b1;
        if (cmd_q == CMD_READ) rdata_d = !rd_ok ? '0 : slot_q == SLOT_RY ? rd_v[4] : rd_v[3];
      end
      ST_ISSUE: if (core.op_ready) state_d = ST_WAIT;
      ST_WAIT: if (core.res_valid) begin
        state_d = ST_IDLE;
        res_avail_d = 1'b1;
        ack_d = !ack_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      req_sync_q <= 1'b0;
      prev_req_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      res_avail_q <= 1'b0;
      cmd_q <= '0;
      slot_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_sync_q <= la_data_in[LA_REQ];
      prev_req_q <= prev_req_d;
      ack_q <= ack_d;
      err_q <= err_d;
      res_avail_q <= res_avail_d;
      cmd_q <= cmd_d;
      slot_q <= slot_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_bec_la_loader.sv
// tb_bec_la_loader: randomized scoreboard bench for bec_la_loader with a behavioural word-array model and a simple core responder
module tb_bec_la_loader;
  import bec_pkg::*;
  localparam int W = 163;
  localparam int N = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] la_data_in = '0;
  logic [63:0] la_oenb = '0;
  logic [63:0] la_data_out;
  bec_la_loader_if #(.WIDTH(W)) core_if ();
  bec_la_loader #(.WIDTH(W), .WORDS(N)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .la_data_in(la_data_in), .la_oenb(la_oenb),
    .la_data_out(la_data_out), .core(core_if)
  );
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  task automatic check(string name, logic [191:0] act, logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {logic err; logic avail; logic [31:0] rdata;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] mk[3][N];
  logic [31:0] mr[2][N];
  logic m_err, m_avail;
  logic [31:0] m_rdata;
  logic [W-1:0] next_rx, next_ry;
  int ready_delay = 0;
  int res_delay = 0;
  bit core_hold = 1'b0;
  int ack_cnt = 0;
  logic last_ack = 1'b0;

  function automatic logic [31:0] wmask(int i);
    int bits;
    bits = W - 32 * i;
    return bits >= 32 ? 32'hffffffff : (32'h1 << bits) - 32'h1;
  endfunction
  function automatic logic [W-1:0] pack(int s);
    logic [32*N-1:0] t;
    for (int i = 0; i < N; i++) t[i*32 +: 32] = mk[s][i];
    return t[W-1:0];
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction
  task automatic set_res(int s, logic [W-1:0] v);
    logic [32*N-1:0] t;
    t = '0;
    t[W-1:0] = v;
    for (int i = 0; i < N; i++) mr[s][i] = t[i*32 +: 32];
  endtask
  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 3; s++) mk[s][i] = '0;
      for (int s = 0; s < 2; s++) mr[s][i] = '0;
    end
    m_err = 1'b0;
    m_avail = 1'b0;
  endtask
  task automatic model_cmd(logic [2:0] c, logic [2:0] s, logic [2:0] i, logic [31:0] w);
    case (c)
      CMD_NOP: ;
      CMD_WRITE: if (i >= N || s > 2) m_err = 1'b1; else mk[s][i] = w & wmask(int'(i));
      CMD_READ: if (i >= N || s > 1) begin m_err = 1'b1; m_rdata = '0; end else m_rdata = mr[s][i];
      CMD_START: begin m_avail = 1'b1; set_res(0, next_rx); set_res(1, next_ry); end
      CMD_CLEAR: model_clear();
      default: m_err = 1'b1;
    endcase
    exp_q.push_back({m_err, m_avail, m_rdata});
  endtask

  task automatic drive(logic [2:0] c, logic [2:0] s, logic [2:0] i, logic [31:0] w);
    @(negedge clk);
    la_data_in[63:42] = 22'($urandom);
    la_data_in[40:38] = i;
    la_data_in[37:35] = s;
    la_data_in[34:32] = c;
    la_data_in[31:0] = w;
    la_data_in[41] = ~la_data_in[41];
  endtask
  task automatic issue(logic [2:0] c, logic [2:0] s, logic [2:0] i, logic [31:0] w);
    drive(c, s, i, w);
    model_cmd(c, s, i, w);
  endtask
  task automatic wait_ack(int n, output int lat);
    int c0;
    c0 = ack_cnt;
    lat = 0;
    while (ack_cnt < c0 + n && lat < 200) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("ack_arrived", ack_cnt >= c0 + n, 1);
  endtask
  task automatic cmd(logic [2:0] c, logic [2:0] s, logic [2:0] i, logic [31:0] w);
    int lat;
    issue(c, s, i, w);
    wait_ack(1, lat);
    if (c != CMD_START) check("ack_latency", lat, 3);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    la_data_in = '0;
    la_oenb = '0;
    @(negedge clk);
    check("rst_op_valid", core_if.op_valid, 0);
    check("rst_res_ready", core_if.res_ready, 0);
    check("rst_la_out", la_data_out, 0);
    check("rst_op_k", core_if.op_k, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    m_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (rst) last_ack = la_data_out[32];
    else if (la_data_out[32] !== last_ack) begin
      last_ack = la_data_out[32];
      ack_cnt++;
      check("ack_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ack_status", {la_data_out[35:33], la_data_out[31:0]}, {mon_e.err, mon_e.avail, 1'b0, mon_e.rdata});
      end
    end
  end

  initial begin
    core_if.op_ready = 1'b0;
    core_if.res_valid = 1'b0;
    core_if.res_x = '0;
    core_if.res_y = '0;
    forever begin
      @(negedge clk);
      if (core_if.op_valid && !rst) begin
        for (int d = 0; d < ready_delay; d++) begin
          check("op_valid_hold", core_if.op_valid, 1);
          check("busy_issue", la_data_out[33], 1);
          check("op_k_stable", core_if.op_k, pack(0));
          @(negedge clk);
        end
        check("op_k", core_if.op_k, pack(0));
        check("op_x", core_if.op_x, pack(1));
        check("op_y", core_if.op_y, pack(2));
        core_if.op_ready = 1'b1;
        @(negedge clk);
        core_if.op_ready = 1'b0;
        check("op_valid_drop", core_if.op_valid, 0);
        check("res_ready_wait", core_if.res_ready, 1);
        if (!core_hold) begin
          repeat (res_delay) @(negedge clk);
          core_if.res_x = next_rx;
          core_if.res_y = next_ry;
          core_if.res_valid = 1'b1;
          @(negedge clk);
          core_if.res_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, lat, r;
    logic [2:0] c, s, i;
    logic [31:0] w;
    next_rx = '0;
    next_ry = '0;
    m_rdata = '0;
    model_clear();
    do_reset();
    for (int k = 0; k < N; k++) cmd(CMD_WRITE, SLOT_K, 3'(k), 32'h11111111 * (k + 1));
    check("op_k_low", core_if.op_k[31:0], 32'h11111111);
    check("op_k_top", core_if.op_k[162:160], 3'd6);
    cmd(CMD_READ, SLOT_RX, 3'd0, 32'd0);
    for (int k = 0; k < N; k++) begin
      cmd(CMD_WRITE, SLOT_X, 3'(k), $urandom);
      cmd(CMD_WRITE, SLOT_Y, 3'(k), $urandom);
    end
    ready_delay = 10;
    res_delay = 2;
    next_rx = 163'd1;
    next_ry = 163'd1 << 162;
    cmd(CMD_START, 3'd0, 3'd0, 32'd0);
    check("res_avail", la_data_out[34], 1);
    cmd(CMD_READ, SLOT_RY, 3'd5, 32'd0);
    check("rdata_ry5", la_data_out[31:0], 32'h4);
    cmd(CMD_READ, SLOT_RX, 3'd0, 32'd0);
    check("rdata_rx0", la_data_out[31:0], 32'h1);
    cmd(CMD_WRITE, SLOT_K, 3'd6, 32'hdeadbeef);
    check("err_idx", la_data_out[35], 1);
    cmd(3'd7, 3'd0, 3'd0, 32'hffffffff);
    check("err_cmd7", la_data_out[35], 1);
    check("k_unchanged", core_if.op_k, pack(0));
    check("x_unchanged", core_if.op_x, pack(1));
    cmd(CMD_CLEAR, 3'd0, 3'd0, 32'd0);
    check("clear_err", la_data_out[35], 0);
    check("clear_avail", la_data_out[34], 0);
    check("clear_k", core_if.op_k, 0);
    cmd(CMD_READ, SLOT_RY, 3'd5, 32'd0);
    check("clear_read", la_data_out[31:0], 0);
    la_oenb[41] = 1'b1;
    c0 = ack_cnt;
    drive(CMD_NOP, 3'd0, 3'd0, 32'd0);
    repeat (8) @(negedge clk);
    check("oenb_no_ack", ack_cnt, c0);
    check("oenb_idle", la_data_out[33], 0);
    la_oenb[41] = 1'b0;
    model_cmd(CMD_NOP, 3'd0, 3'd0, 32'd0);
    wait_ack(1, lat);
    for (int k = 0; k < N; k++) cmd(CMD_WRITE, 3'(k % 3), 3'(k), $urandom);
    ready_delay = 15;
    next_rx = rnd();
    next_ry = rnd();
    c0 = ack_cnt;
    issue(CMD_START, 3'd0, 3'd0, 32'd0);
    repeat (4) @(negedge clk);
    drive(CMD_CLEAR, 3'd0, 3'd0, 32'd0);
    drive(CMD_WRITE, SLOT_K, 3'd0, 32'h12345678);
    issue(CMD_READ, SLOT_RY, 3'd2, 32'd0);
    wait_ack(2, lat);
    repeat (10) @(negedge clk);
    check("pending_once", ack_cnt, c0 + 2);
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      c = r == 0 ? CMD_NOP : (r <= 3 || r == 9) ? CMD_WRITE : r <= 5 ? CMD_READ :
          r == 6 ? CMD_START : r == 7 ? CMD_CLEAR : 3'($urandom_range(5, 7));
      s = 3'($urandom_range(0, 3));
      i = $urandom_range(0, 5) == 0 ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      w = $urandom;
      if (c == CMD_START) begin
        next_rx = rnd();
        next_ry = rnd();
        ready_delay = $urandom_range(0, 3);
        res_delay = $urandom_range(0, 3);
      end
      cmd(c, s, i, w);
    end
    check("final_k", core_if.op_k, pack(0));
    check("final_y", core_if.op_y, pack(2));
    core_hold = 1'b1;
    ready_delay = 2;
    issue(CMD_START, 3'd0, 3'd0, 32'd0);
    lat = 0;
    while (!core_if.res_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("reached_wait", core_if.res_ready, 1);
    do_reset();
    core_hold = 1'b0;
    cmd(CMD_WRITE, SLOT_X, 3'd1, 32'hcafef00d);
    check("post_rst_x", core_if.op_x, pack(1));
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
